mbist_march_ctrl: RTL

- Parametrised successor to the single-algorithm MBIST controller.
- Runs a selectable March algorithm (MATS+ or March C-) over a single-port test memory of 2^ADDR_W words × DATA_W bits.
- Keeps running after the first miscompare; logs the first failing address and syndrome, and counts all miscompares.
- Sits between the test-control logic (start/done/fail) and the memory under test.

---
 rtl/mbist_pkg.sv | 60 ++++++
 rtl/mbist_fail_log.sv | 48 ++++
 rtl/mbist_march_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// Shared types and March element tables for the MBIST march controller.
package mbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CMP,
    S_NEXT_EL,
    S_DONE
  } state_t;

  // One March element. Values are 0 = background, 1 = inverted background.
  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic read_val;
    logic has_write;
    logic write_val;
  } el_t;

  localparam logic ALGO_MATSP  = 1'b0;
  localparam logic ALGO_MARCHC = 1'b1;

  localparam int MATSP_N_EL  = 3;
  localparam int MARCHC_N_EL = 6;

  // Field order: dir_down, has_read, read_val, has_write, write_val
  localparam el_t EL_W0      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam el_t EL_UP_R0W1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam el_t EL_UP_R1W0 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam el_t EL_DN_R0W1 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam el_t EL_DN_R1W0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam el_t EL_UP_R0   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Write-only elements are swept ascending.
  localparam el_t [0:MATSP_N_EL-1] MATSP_TBL = {
    EL_W0, EL_UP_R0W1, EL_DN_R1W0
  };

  localparam el_t [0:MARCHC_N_EL-1] MARCHC_TBL = {
    EL_W0, EL_UP_R0W1, EL_UP_R1W0, EL_DN_R0W1, EL_DN_R1W0, EL_UP_R0
  };

  function automatic el_t get_el(input logic algo, input logic [2:0] idx);
    el_t e;
    e = '0;
    if (algo == ALGO_MARCHC) begin
      if (idx < 3'(MARCHC_N_EL)) e = MARCHC_TBL[idx];
    end else begin
      if (idx < 3'(MATSP_N_EL)) e = MATSP_TBL[idx[1:0]];
    end
    return e;
  endfunction

  function automatic logic [2:0] last_el(input logic algo);
    return (algo == ALGO_MARCHC) ? 3'(MARCHC_N_EL - 1) : 3'(MATSP_N_EL - 1);
  endfunction

endpackage

// File: rtl/mbist_fail_log.sv
// Read-data comparator with first-fail capture and saturating miscompare count.
module mbist_fail_log #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int FCNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_cmp_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [DATA_W-1:0] i_dout,
  output logic              o_fail,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data,
  output logic [FCNT_W-1:0] o_fail_cnt
);

  logic [DATA_W-1:0] w_syn;
  logic              w_miss;

  assign w_syn  = i_dout ^ i_exp;
  assign w_miss = i_cmp_en && (w_syn != '0);

  // Only the first miscompare of a run is captured; every one is counted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fail      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_fail_cnt  <= '0;
    end else if (i_clear) begin
      o_fail      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_fail_cnt  <= '0;
    end else if (w_miss) begin
      o_fail <= 1'b1;
      if (!o_fail) begin
        o_fail_addr <= i_addr;
        o_fail_data <= w_syn;
      end
      if (o_fail_cnt != '1) o_fail_cnt <= o_fail_cnt + FCNT_W'(1);
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March-algorithm MBIST controller (MATS+ / March C-) for a single-port memory.
// Optional build macro MBIST_CHECKERBOARD_EN: rerun the algorithm with a 0x55.. background.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_WR      | write-only element, one address per cycle
// S_RD      | read issue for a read element
// S_CMP     | compare returned data; write new value for r,w elements
// S_NEXT_EL | element hand-over, resolved in the same cycle, never registered
// S_DONE    | run complete, results held until the next start
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int FCNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_algo_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data,
  output logic [FCNT_W-1:0] o_fail_cnt,
  output logic              o_read,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout
);

  state_t            r_state, w_state_nxt;
  logic              r_algo, w_algo_nxt;
  logic [2:0]        r_el, w_el_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt, w_addr_step;
  logic              r_read, r_write, w_read_nxt, w_write_nxt;
  logic [DATA_W-1:0] r_mem_din, w_din_nxt;
  logic [DATA_W-1:0] w_bg_cur, w_bg_nxt, w_exp;
  el_t               w_el, w_nel;
  logic              w_last_addr, w_el_end, w_clear, w_cmp_en, w_unused;

`ifdef MBIST_CHECKERBOARD_EN
  logic r_pass, w_pass_nxt;

  function automatic logic [DATA_W-1:0] bg_word(input logic pass);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W; i++) w[i] = pass & ~i[0];
    return w;
  endfunction

  assign w_bg_cur = bg_word(r_pass);

  // Background pass select: 0 = solid, 1 = checkerboard.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pass <= 1'b0;
    else       r_pass <= w_pass_nxt;
  end
`else
  assign w_bg_cur = '0;
`endif

  assign w_el        = get_el(r_algo, r_el);
  assign w_last_addr = w_el.dir_down ? (r_mem_addr == '0) : (r_mem_addr == '1);
  assign w_addr_step = w_el.dir_down ? (r_mem_addr - ADDR_W'(1)) : (r_mem_addr + ADDR_W'(1));
  assign w_cmp_en    = (r_state == S_CMP);
  assign w_exp       = w_el.read_val ? ~w_bg_cur : w_bg_cur;
  assign w_unused    = ^{w_el.has_read, w_el.has_write, w_el.write_val, w_nel.read_val};

  // Next state, sweep position and the memory op that goes out next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_algo_nxt  = r_algo;
    w_el_nxt    = r_el;
    w_addr_nxt  = r_mem_addr;
    w_clear     = 1'b0;
    w_el_end    = 1'b0;
    w_nel       = '0;
    w_bg_nxt    = '0;
    w_read_nxt  = 1'b0;
    w_write_nxt = 1'b0;
    w_din_nxt   = '0;
`ifdef MBIST_CHECKERBOARD_EN
    w_pass_nxt  = r_pass;
`endif

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_clear     = 1'b1;
          w_algo_nxt  = i_algo_sel;
          w_el_nxt    = '0;
          w_state_nxt = S_NEXT_EL;
`ifdef MBIST_CHECKERBOARD_EN
          w_pass_nxt  = 1'b0;
`endif
        end
      end
      S_WR: begin
        if (w_last_addr) w_el_end = 1'b1;
        else             w_addr_nxt = w_addr_step;
      end
      S_RD: w_state_nxt = S_CMP;
      S_CMP: begin
        if (w_last_addr) begin
          w_el_end = 1'b1;
        end else begin
          w_addr_nxt  = w_addr_step;
          w_state_nxt = S_RD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_el_end) begin
      if (r_el != last_el(r_algo)) begin
        w_el_nxt    = r_el + 3'd1;
        w_state_nxt = S_NEXT_EL;
      end
`ifdef MBIST_CHECKERBOARD_EN
      else if (!r_pass) begin
        w_pass_nxt  = 1'b1;
        w_el_nxt    = '0;
        w_state_nxt = S_NEXT_EL;
      end
`endif
      else begin
        w_state_nxt = S_DONE;
      end
    end

    // Element hand-over costs no cycle: jump straight to its first op.
    w_nel = get_el(w_algo_nxt, w_el_nxt);
    if (w_state_nxt == S_NEXT_EL) begin
      w_state_nxt = w_nel.has_read ? S_RD : S_WR;
      w_addr_nxt  = w_nel.dir_down ? '1 : '0;
    end

`ifdef MBIST_CHECKERBOARD_EN
    w_bg_nxt = bg_word(w_pass_nxt);
`endif

    w_read_nxt = (w_state_nxt == S_RD);
    if ((w_state_nxt == S_WR) || ((w_state_nxt == S_CMP) && w_nel.has_write)) begin
      w_write_nxt = 1'b1;
      w_din_nxt   = w_nel.write_val ? ~w_bg_nxt : w_bg_nxt;
    end
  end

  // State, sweep and registered memory-side outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_algo     <= 1'b0;
      r_el       <= '0;
      r_mem_addr <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_mem_din  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_algo     <= w_algo_nxt;
      r_el       <= w_el_nxt;
      r_mem_addr <= w_addr_nxt;
      r_read     <= w_read_nxt;
      r_write    <= w_write_nxt;
      r_mem_din  <= w_din_nxt;
    end
  end

  mbist_fail_log #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .FCNT_W (FCNT_W)
  ) u_fail_log (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_cmp_en    (w_cmp_en),
    .i_addr      (r_mem_addr),
    .i_exp       (w_exp),
    .i_dout      (i_mem_dout),
    .o_fail      (o_fail),
    .o_fail_addr (o_fail_addr),
    .o_fail_data (o_fail_data),
    .o_fail_cnt  (o_fail_cnt)
  );

  assign o_busy     = (r_state == S_WR) || (r_state == S_RD) || (r_state == S_CMP);
  assign o_done     = (r_state == S_DONE);
  assign o_read     = r_read;
  assign o_write    = r_write;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_din  = r_mem_din;

endmodule
